attack_arbiter: RTL

ATTACK_ARBITER -- requirements
Module: attack_arbiter

---
 rtl/attack_arbiter.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/attack_arbiter.sv
// Two-player attack arbiter: grants one attack window at a time, applies damage at window end.
// Optional ATTACK_ARBITER_QUEUE_EN latches the defender's request during a window and grants it back-to-back.
module attack_arbiter #(
  parameter int unsigned ATTACK_CYCLES = 33_300_000,
  parameter int unsigned DAMAGE        = 10,
  parameter int unsigned MAX_HEALTH    = 100
) (
  input  logic       clk,
  input  logic       rst_l,
  input  logic       p1_attack_req,
  input  logic       p2_attack_req,
  input  logic       in_range,
  input  logic       p1_crouch,
  input  logic       p2_crouch,
  output logic       p1_attack_grant,
  output logic       p2_attack_grant,
  output logic [6:0] p1_health,
  output logic [6:0] p2_health,
  output logic       busy,
  output logic       game_over,
  output logic       winner
);

  typedef enum logic [1:0] {IDLE, ACTIVE, OVER} state_t;

  localparam logic [25:0] LAST_CNT = 26'(ATTACK_CYCLES);
  localparam logic [6:0]  DMG      = 7'(DAMAGE);
  localparam logic [6:0]  HMAX     = 7'(MAX_HEALTH);

  state_t      state;
  logic [25:0] cnt;
  logic        attacker;   // 0 = player 1, 1 = player 2
  logic        prio_p2;    // player 2 wins the next tie
  logic        pick_p2;
  logic        hit;
  logic        last_cycle;
  logic [6:0]  def_health;
  logic [6:0]  def_next;

`ifdef ATTACK_ARBITER_QUEUE_EN
  logic p1_req_d;
  logic p2_req_d;
  logic pending;
  logic other_rise;
`endif

  always_comb begin
    pick_p2    = p2_attack_req & (~p1_attack_req | prio_p2);
    last_cycle = (cnt == LAST_CNT);
    def_health = attacker ? p1_health : p2_health;
    hit        = in_range & ~(attacker ? p1_crouch : p2_crouch);
    def_next   = def_health;
    if (hit) def_next = (def_health > DMG) ? def_health - DMG : '0;
`ifdef ATTACK_ARBITER_QUEUE_EN
    other_rise = attacker ? (p1_attack_req & ~p1_req_d) : (p2_attack_req & ~p2_req_d);
`endif
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state           <= IDLE;
      cnt             <= '0;
      attacker        <= 1'b0;
      prio_p2         <= 1'b0;
      p1_attack_grant <= 1'b0;
      p2_attack_grant <= 1'b0;
      p1_health       <= HMAX;
      p2_health       <= HMAX;
      busy            <= 1'b0;
      game_over       <= 1'b0;
      winner          <= 1'b0;
`ifdef ATTACK_ARBITER_QUEUE_EN
      p1_req_d        <= 1'b0;
      p2_req_d        <= 1'b0;
      pending         <= 1'b0;
`endif
    end else begin
      p1_attack_grant <= 1'b0;
      p2_attack_grant <= 1'b0;
`ifdef ATTACK_ARBITER_QUEUE_EN
      p1_req_d        <= p1_attack_req;
      p2_req_d        <= p2_attack_req;
`endif
      case (state)
        IDLE: begin
          busy <= 1'b0;
          if (p1_attack_req | p2_attack_req) begin
            p1_attack_grant <= ~pick_p2;
            p2_attack_grant <= pick_p2;
            attacker        <= pick_p2;
            prio_p2         <= ~pick_p2;
            cnt             <= '0;
            state           <= ACTIVE;
          end
        end
        ACTIVE: begin
          if (!last_cycle) begin
            cnt  <= cnt + 26'd1;
            busy <= 1'b1;
`ifdef ATTACK_ARBITER_QUEUE_EN
            pending <= pending | other_rise;
`endif
          end else begin
            busy <= 1'b0;
            if (attacker) p1_health <= def_next;
            else          p2_health <= def_next;
            if (def_next == '0) begin
              state     <= OVER;
              game_over <= 1'b1;
              winner    <= attacker;
`ifdef ATTACK_ARBITER_QUEUE_EN
              pending   <= 1'b0;
`endif
            end
`ifdef ATTACK_ARBITER_QUEUE_EN
            // A pending defender request restarts the window without visiting IDLE.
            else if (pending | other_rise) begin
              p1_attack_grant <= attacker;
              p2_attack_grant <= ~attacker;
              attacker        <= ~attacker;
              prio_p2         <= attacker;
              cnt             <= '0;
              pending         <= 1'b0;
            end
`endif
            else begin
              state <= IDLE;
            end
          end
        end
        OVER: begin
          busy <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
